siso_xfer_ctrl: RTL and testbench
=================================

Name: siso_xfer_ctrl

Overview:
- Controller that sequences an external serial-in/serial-out shift chain of DEPTH flops.
- Accepts a WIDTH-bit parallel word on a valid/ready input and drives it MSB-first into the chain.
- Waits out the chain latency, collects the emerging bits back into a parallel word, and presents that word on a valid/ready output.
- Sits between parallel producers/consumers and the serial delay chain. Used for chain bring-up, delay-line transport and loopback checking.

Parameters:
- WIDTH, 8, bits per transferred word (>=2).
- DEPTH, 4, number of flops in the external chain, i.e. sr_din-to-sr_dout latency in enabled clocks (>=1).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  word to send, MSB first.
- sr_en  output  1  shift enable to the chain; the chain advances only on edges where this is 1.
- sr_din  output  1  serial bit into the chain.
- sr_dout  input  1  serial bit out of the chain.
- out_valid  output  1  received word available.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  received word.

Behaviour:
- The only clock is clock. The only reset is reset_n, which is asynchronous and active-low.
- Reset (async assert, sync deassert by the system):
  - state=IDLE, cnt=0, tx_reg=0, rx_reg=0.
  - Outputs: in_ready=1, sr_en=0, sr_din=0, out_valid=0, out_data=0.
- The chain itself is not reset. Residual chain contents are never captured, because capture starts only after DEPTH enabled shifts.
- States: IDLE, SHIFT, FLUSH, DONE. in_ready = (state==IDLE).
- IDLE:
  - On in_valid&&in_ready: tx_reg<=in_data, rx_reg<=0, cnt<=0, go to SHIFT.
  - in_valid while not in IDLE is ignored; the producer must hold it.
- SHIFT (cnt 0..WIDTH-1):
  - sr_en=1, sr_din=tx_reg[WIDTH-1], tx_reg shifts left each edge.
  - At cnt==WIDTH-1, go to FLUSH.
- FLUSH (cnt WIDTH..WIDTH+DEPTH-1):
  - sr_en=1, sr_din=0.
  - At cnt==WIDTH+DEPTH-1, go to DONE.
- Capture, in SHIFT or FLUSH: on every edge with cnt>=DEPTH, rx_reg<={rx_reg[WIDTH-2:0],sr_dout}.
  - Capture happens exactly WIDTH times, so rx_reg ends equal to the sent word through an ideal chain.
  - If DEPTH>=WIDTH, capture occurs only in FLUSH. This must still work.
- cnt:
  - Width is clog2(WIDTH+DEPTH).
  - Increments every SHIFT/FLUSH edge and clears on entry to DONE. It never wraps within a transfer.
- DONE:
  - sr_en=0, out_valid=1, out_data=rx_reg, held stable until out_ready.
  - On out_valid&&out_ready, go to IDLE (out_valid=0 next cycle).
  - A new word is accepted at the earliest one cycle after the output handshake.
- Latency: acceptance edge plus WIDTH+DEPTH shift cycles; out_valid rises on the next cycle (WIDTH+DEPTH+1 cycles after acceptance). The default is 13.
- Reset mid-transfer: everything returns to reset values immediately. The partial word is discarded and no out_valid is issued.
- sr_din is a registered output, so there is no combinational path from in_data to sr_din.

Optional Feature:
- Macro: SISO_XFER_CTRL_CHECK_EN.
- With the macro defined:
  - Adds output mismatch (1 bit, reset 0).
  - A shadow copy of the sent word is kept. In DONE, mismatch = (rx_reg != shadow), valid only while out_valid=1.
  - mismatch clears on leaving DONE.
- Without the macro: the port and shadow register do not exist, and behaviour is otherwise identical.

Decomposition:
- Package siso_xfer_pkg:
  - state enum (IDLE, SHIFT, FLUSH, DONE) as 2-bit typedef.
  - function cnt_width(WIDTH, DEPTH) returning clog2(WIDTH+DEPTH).
- One natural sub-module, siso_xfer_cnt: a loadable/clearable up-counter with a terminal-value compare output, used for cnt.
- The bench instantiates a DEPTH-flop enable-gated SISO chain as the external datapath.

Test Plan (WIDTH=8, DEPTH=4):
- Single word: in_data=8'hE9 accepted → sr_din sequence 1,1,1,0,1,0,0,1,0,0,0,0 with sr_en=1 for 12 cycles → out_valid 13 cycles after acceptance, out_data=8'hE9.
- Back-to-back:
  - Words 8'h00, 8'hFF, 8'hA5, 8'h01 with out_ready tied 1 → each returned intact, in order.
  - in_ready high one cycle after each output handshake.
- Output stall: 8'h3C, out_ready low 5 cycles → out_valid/out_data=8'h3C held stable, in_ready=0, sr_en=0 throughout; IDLE after release.
- Busy input: in_valid with 8'h55 asserted during SHIFT → not accepted until IDLE; then returned as 8'h55.
- Reset mid-transfer: reset_n low at cnt=5 of 8'hC3 → all outputs at reset values immediately, no out_valid. Next word 8'h81 is returned correct despite a dirty chain.
- CHECK_EN:
  - Bench chain inverts one bit in flight → mismatch=1 with out_valid.
  - Clean chain with 8'h7E → mismatch=0.

Source files
------------

// File: rtl/siso_xfer_pkg.sv
// Shared types and helpers for the SISO shift-chain transfer controller.
package siso_xfer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StFlush,
    StDone
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width, input int unsigned depth);
    return $clog2(width + depth);
  endfunction

endpackage

// File: rtl/siso_xfer_cnt.sv
// Loadable, clearable up-counter with a terminal-value compare output.
module siso_xfer_cnt #(
  parameter int unsigned Width   = 4,
  parameter int unsigned TermVal = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ld_i,
  input  logic [Width-1:0] ld_val_i,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o,
  output logic             term_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = (cnt_q == Width'(TermVal));

endmodule

// File: rtl/siso_xfer_ctrl.sv
// Sequences a word MSB-first through an external DEPTH-flop SISO chain and collects it back.
// Optional loopback compare output enabled by SISO_XFER_CTRL_CHECK_EN.
module siso_xfer_ctrl
  import siso_xfer_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             sr_en,
  output logic             sr_din,
  input  logic             sr_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef SISO_XFER_CTRL_CHECK_EN
  ,
  output logic             mismatch
`endif
);

  localparam int unsigned CW = cnt_width(WIDTH, DEPTH);
  localparam logic [CW-1:0] ShiftLast = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CapFirst  = CW'(DEPTH);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] tx_d, tx_q;
  logic [WIDTH-1:0] rx_d, rx_q;
  logic [CW-1:0]    cnt;
  logic             cnt_term, cnt_clr, cnt_ld, cnt_inc;

  siso_xfer_cnt #(
    .Width  (CW),
    .TermVal(WIDTH + DEPTH - 1)
  ) u_cnt (
    .clk_i   (clock),
    .rst_ni  (reset_n),
    .clr_i   (cnt_clr),
    .ld_i    (cnt_ld),
    .ld_val_i('0),
    .inc_i   (cnt_inc),
    .cnt_o   (cnt),
    .term_o  (cnt_term)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cnt_clr   = 1'b0;
    cnt_ld    = 1'b0;
    cnt_inc   = 1'b0;
    sr_en     = 1'b0;
    out_valid = 1'b0;
    in_ready  = (state_q == StIdle);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          tx_d    = in_data;
          rx_d    = '0;
          cnt_ld  = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        sr_en   = 1'b1;
        cnt_inc = 1'b1;
        // Zeros shifted in behind the word keep sr_din low through FLUSH.
        tx_d    = {tx_q[WIDTH-2:0], 1'b0};
        if (cnt == ShiftLast) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        sr_en   = 1'b1;
        cnt_inc = 1'b1;
        if (cnt_term) begin
          cnt_clr = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Bits reach sr_dout only after DEPTH enabled shifts; earlier ones are stale chain contents.
    if (sr_en && (cnt >= CapFirst)) begin
      rx_d = {rx_q[WIDTH-2:0], sr_dout};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      tx_q    <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
    end
  end

  assign sr_din   = tx_q[WIDTH-1];
  assign out_data = (state_q == StDone) ? rx_q : '0;

`ifdef SISO_XFER_CTRL_CHECK_EN
  logic [WIDTH-1:0] shadow_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
    end else if (state_q == StIdle && in_valid) begin
      shadow_q <= in_data;
    end
  end

  assign mismatch = (state_q == StDone) && (rx_q != shadow_q);
`endif

endmodule

// File: tb/tb_siso_xfer_ctrl.sv
// Directed self-checking bench for siso_xfer_ctrl with a behavioural enable-gated SISO chain.
module tb_siso_xfer_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             sr_en, sr_din, sr_dout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH-1:0] chain;
  logic             inv = 1'b0;
`ifdef SISO_XFER_CTRL_CHECK_EN
  logic             mismatch;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // External chain: not reset, advances only when enabled; inv corrupts one bit in flight.
  always @(posedge clock) begin
    if (sr_en) chain <= {chain[DEPTH-2:0], sr_din};
  end
  assign sr_dout = chain[DEPTH-1] ^ inv;

  siso_xfer_ctrl #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .sr_en    (sr_en),
    .sr_din   (sr_din),
    .sr_dout  (sr_dout),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
`ifdef SISO_XFER_CTRL_CHECK_EN
    ,
    .mismatch (mismatch)
`endif
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    checks++;
    if ({in_ready, sr_en, sr_din, out_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1000", {in_ready, sr_en, sr_din, out_valid});
    end
    checks++;
    if (out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data got %h want 00", out_data);
    end
`ifdef SISO_XFER_CTRL_CHECK_EN
    checks++;
    if (mismatch !== 1'b0) begin
      errors++;
      $display("FAIL reset_mismatch got %b want 0", mismatch);
    end
`endif
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [11:0] seq;
    int n;
    seq = 12'b1110_1001_0000;
    in_valid = 1'b1;
    in_data  = 8'hE9;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (sr_en !== 1'b1 || sr_din !== seq[11-i] || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL single_shift%0d got en=%b din=%b ov=%b want en=1 din=%b ov=0",
                 i, sr_en, sr_din, out_valid, seq[11-i]);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hE9 || sr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_done got ov=%b data=%h en=%b want ov=1 data=e9 en=0",
               out_valid, out_data, sr_en);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    n = 0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [4];
    int n;
    words = '{8'h00, 8'hFF, 8'hA5, 8'h01};
    out_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      in_valid = 1'b1;
      in_data  = words[w];
      n = 0;
      while (!in_ready && n < 30) begin
        tick();
        n++;
      end
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 30) begin
        tick();
        n++;
      end
      checks++;
      if (n != 12) begin
        errors++;
        $display("FAIL b2b_latency%0d got %0d edges want 12", w, n);
      end
      checks++;
      if (out_data !== words[w]) begin
        errors++;
        $display("FAIL b2b_data%0d got %h want %h", w, out_data, words[w]);
      end
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready%0d got ir=%b ov=%b want ir=1 ov=0", w, in_ready, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || in_ready !== 1'b0 || sr_en !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d got ov=%b data=%h ir=%b en=%b want ov=1 data=3c ir=0 en=0",
                 i, out_valid, out_data, in_ready, sr_en);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got ir=%b ov=%b want ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_busy_input();
    int n;
    in_valid = 1'b1;
    in_data  = 8'h12;
    tick();
    in_data  = 8'h55;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready got %b want 0", in_ready);
    end
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (out_data !== 8'h12) begin
      errors++;
      $display("FAIL busy_first got %h want 12", out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h55) begin
      errors++;
      $display("FAIL busy_second got ov=%b data=%h want ov=1 data=55", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    in_valid = 1'b1;
    in_data  = 8'hC3;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, sr_en, sr_din, out_valid} !== 4'b1000 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL midreset_async got ir/en/din/ov=%b data=%h want 1000 data=00",
               {in_ready, sr_en, sr_din, out_valid}, out_data);
    end
    tick();
    tick();
    #2 reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midreset_no_valid got out_valid seen=%b want 0", seen);
    end
    in_valid = 1'b1;
    in_data  = 8'h81;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h81) begin
      errors++;
      $display("FAIL midreset_next got ov=%b data=%h want ov=1 data=81", out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

`ifdef SISO_XFER_CTRL_CHECK_EN
  task automatic test_check_en();
    int n;
    // Bit captured at cnt=6 is bit 5 of the word, so A5 returns as 85.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    inv = 1'b1;
    tick();
    inv = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h85 || mismatch !== 1'b1) begin
      errors++;
      $display("FAIL check_corrupt got ov=%b data=%h mm=%b want ov=1 data=85 mm=1",
               out_valid, out_data, mismatch);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (mismatch !== 1'b0) begin
      errors++;
      $display("FAIL check_clear got %b want 0", mismatch);
    end
    in_valid = 1'b1;
    in_data  = 8'h7E;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h7E || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL check_clean got ov=%b data=%h mm=%b want ov=1 data=7e mm=0",
               out_valid, out_data, mismatch);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_busy_input();
    test_reset_mid();
`ifdef SISO_XFER_CTRL_CHECK_EN
    test_check_en();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
